// File: rtl/melody_pkg.sv
// Shared constants, note payload and FSM states for the melody sequencer.
package melody_pkg;

    localparam int unsigned DUR_W  = 12;
    localparam int unsigned HP_W   = 20;
    localparam int unsigned DATA_W = 32;

    localparam logic [3:0] OFS_NOTE   = 4'h0;
    localparam logic [3:0] OFS_CTRL   = 4'h4;
    localparam logic [3:0] OFS_STATUS = 4'h8;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        HOLD,
        SILENCE
    } state_e;

    typedef struct packed {
        logic [DUR_W-1:0] dur_ms;
        logic [HP_W-1:0]  half_period;
    } note_t;

    // A zero duration still plays for one millisecond.
    function automatic logic [DUR_W-1:0] eff_dur(input logic [DUR_W-1:0] d);
        return (d == '0) ? DUR_W'(1) : d;
    endfunction

endpackage

// File: rtl/melody_if.sv
// CPU register port plus the buzzer write port driven by the sequencer.
interface melody_if;

    logic        wr;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic        rd;
    logic [31:0] raddr;
    logic [31:0] rdata;
    logic        buz_wr;
    logic [31:0] buz_waddr;
    logic [31:0] buz_wdata;

    modport slave (
        input  wr, waddr, wdata, rd, raddr,
        output rdata, buz_wr, buz_waddr, buz_wdata
    );

    modport master (
        output wr, waddr, wdata, rd, raddr,
        input  rdata, buz_wr, buz_waddr, buz_wdata
    );

endinterface

// File: rtl/melody_fifo.sv
// Synchronous note FIFO; the head entry is visible without read latency.
module melody_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    push_i,
    input  logic                    pop_i,
    input  logic                    flush_i,
    input  logic [WIDTH-1:0]        wdata_i,
    output logic [WIDTH-1:0]        head_c_o,
    output logic                    full_o,
    output logic                    empty_o,
    output logic [$clog2(DEPTH):0]  count_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, rptr_q;
    logic [CW-1:0]    count_q, count_d;
    logic             full_q, empty_q;
    logic             do_push, do_pop;

    // A full FIFO still accepts a push when an entry leaves in the same cycle.
    assign do_push = push_i && !flush_i && (!full_q || pop_i);
    assign do_pop  = pop_i && !flush_i && !empty_q;

    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + CW'(1);
        end else if (!do_push && do_pop) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else if (flush_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            if (do_push) wptr_q <= wptr_q + AW'(1);
            if (do_pop)  rptr_q <= rptr_q + AW'(1);
            count_q <= count_d;
            full_q  <= (count_d == CW'(DEPTH));
            empty_q <= (count_d == '0);
        end
    end

    assign head_c_o = mem_q[rptr_q];
    assign full_o   = full_q;
    assign empty_o  = empty_q;
    assign count_o  = count_q;

endmodule

// File: rtl/melody_seq.sv
// Note sequencer: CPU-loaded note FIFO that reprograms the buzzer tone at each
// note boundary.
module melody_seq
    import melody_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned MS_CYCLES  = 50000,
    parameter logic [31:0] BUZ_BASE   = 32'h0000_0000
) (
    input  logic     clk,
    input  logic     rst_n,
    melody_if.slave  bus
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned PW = (MS_CYCLES > 1) ? $clog2(MS_CYCLES) : 1;

    state_e             state_q, state_d;
    logic               play_q, play_d;
    logic               ovf_q, ovf_d;
    logic [PW-1:0]      presc_q, presc_d;
    logic [DUR_W-1:0]   ms_q, ms_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;
    logic               buz_wr_q, buz_wr_d;
    logic [DATA_W-1:0]  buz_wdata_q, buz_wdata_d;
    logic [DATA_W-1:0]  buz_waddr_q;

    logic               wr_note, wr_ctrl, flush, push, pop, tick;
    logic [DATA_W-1:0]  head_raw;
    note_t              head;
    logic               full, empty;
    logic [CW-1:0]      count;
    logic               unused_addr_bits;

    assign unused_addr_bits = ^{bus.waddr[31:4], bus.raddr[31:4]};

    // Register decode
    assign wr_note = bus.wr && (bus.waddr[3:0] == OFS_NOTE);
    assign wr_ctrl = bus.wr && (bus.waddr[3:0] == OFS_CTRL);
    assign flush   = wr_ctrl && bus.wdata[1];
    assign push    = wr_note && !flush;
    assign play_d  = wr_ctrl ? bus.wdata[0] : play_q;
    assign head    = note_t'(head_raw);
    assign tick    = (presc_q == PW'(MS_CYCLES - 1));

    melody_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_W)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push_i   (push),
        .pop_i    (pop),
        .flush_i  (flush),
        .wdata_i  (bus.wdata),
        .head_c_o (head_raw),
        .full_o   (full),
        .empty_o  (empty),
        .count_o  (count)
    );

    always_comb begin
        ovf_d = ovf_q;
        if (wr_ctrl && bus.wdata[3]) ovf_d = 1'b0;
        if (push && full && !pop)    ovf_d = 1'b1;
    end

    always_comb begin
        rdata_d = rdata_q;
        if (bus.rd) begin
            case (bus.raddr[3:0])
                OFS_CTRL:   rdata_d = {31'b0, play_q};
                OFS_STATUS: rdata_d = {16'b0, 8'(count), 4'b0, ovf_q, empty, full,
                                       (state_q != IDLE)};
                default:    rdata_d = '0;
            endcase
        end
    end

    // Next state, prescaler/ms counter and buzzer writes. Buzzer writes are
    // launched on entry to LOAD/SILENCE so they line up with those states.
    always_comb begin
        state_d     = state_q;
        pop         = 1'b0;
        presc_d     = presc_q;
        ms_d        = ms_q;
        buz_wr_d    = 1'b0;
        buz_wdata_d = buz_wdata_q;

        case (state_q)
            IDLE: begin
                if (play_q && !empty && !flush) state_d = LOAD;
            end
            LOAD: begin
                pop     = 1'b1;
                presc_d = '0;
                ms_d    = eff_dur(head.dur_ms);
                state_d = flush ? SILENCE : HOLD;
            end
            HOLD: begin
                presc_d = tick ? '0 : presc_q + PW'(1);
                if (tick) ms_d = ms_q - DUR_W'(1);
                if (flush || !play_d) begin
                    state_d = SILENCE;
                end else if (tick && (ms_q == DUR_W'(1))) begin
                    state_d = empty ? SILENCE : LOAD;
                end
            end
            SILENCE: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (state_d == LOAD) begin
            buz_wr_d    = 1'b1;
            buz_wdata_d = DATA_W'(head.half_period);
        end else if (state_d == SILENCE) begin
            buz_wr_d    = 1'b1;
            buz_wdata_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            play_q      <= 1'b0;
            ovf_q       <= 1'b0;
            presc_q     <= '0;
            ms_q        <= '0;
            rdata_q     <= '0;
            buz_wr_q    <= 1'b0;
            buz_wdata_q <= '0;
            buz_waddr_q <= BUZ_BASE;
        end else begin
            play_q      <= play_d;
            ovf_q       <= ovf_d;
            presc_q     <= presc_d;
            ms_q        <= ms_d;
            rdata_q     <= rdata_d;
            buz_wr_q    <= buz_wr_d;
            buz_wdata_q <= buz_wdata_d;
            buz_waddr_q <= BUZ_BASE;
        end
    end

    assign bus.rdata     = rdata_q;
    assign bus.buz_wr    = buz_wr_q;
    assign bus.buz_waddr = buz_waddr_q;
    assign bus.buz_wdata = buz_wdata_q;

endmodule
